// File: rtl/uart_rx_ctrl_if.sv
// Receiver/host-side bundle for uart_rx_ctrl.
// The slave modport is the controller; the master modport is the receiver plus host.
// The overrun signal exists only when UART_RX_CTRL_OVERRUN_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          rxclken;
  logic          rx_busy;
  logic [7:0]    dout;
  logic          rdy;
  logic          rdy_clr;
  logic [7:0]    data;
  logic [CW-1:0] count;
`ifdef UART_RX_CTRL_OVERRUN_EN
  logic          overrun;

  modport master (
    output en, rx_busy, dout, rdy_clr,
    input  rxclken, rdy, data, count, overrun
  );

  modport slave (
    input  en, rx_busy, dout, rdy_clr,
    output rxclken, rdy, data, count, overrun
  );
`else
  modport master (
    output en, rx_busy, dout, rdy_clr,
    input  rxclken, rdy, data, count
  );

  modport slave (
    input  en, rx_busy, dout, rdy_clr,
    output rxclken, rdy, data, count
  );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud-enable divider, frame-completion detector and
// a first-word-fall-through byte FIFO with a rdy/rdy_clr host handshake.
// Optional sticky overrun flag: define UART_RX_CTRL_OVERRUN_EN.
module uart_rx_ctrl #(
  parameter int unsigned DIV   = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic          rxclk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned DW = $clog2(DIV);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  // ---------------- baud divider ----------------
  logic [DW-1:0] div_cnt;
  logic          rxclken_q;

  // Free-running 0..DIV-1 counter; pulse on the cycle after it reaches DIV-1
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      rxclken_q <= 1'b0;
    end else if (!bus.en) begin
      div_cnt   <= '0;
      rxclken_q <= 1'b0;
    end else begin
      rxclken_q <= (div_cnt == DW'(DIV - 1));
      div_cnt   <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);
    end
  end

  // ---------------- frame detector ----------------
  logic       busy_q;
  logic [7:0] dout_q;
  state_t     state;
  logic       push_c;

  // Register the receiver flags; dout is captured alongside so the byte at the fall is kept
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      busy_q <= bus.rx_busy;
      dout_q <= bus.dout;
    end
  end

  // Two-state frame tracker: a push only follows an observed busy period
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (busy_q)  state <= BUSY;
        BUSY:    if (!busy_q) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Push fires on the BUSY->IDLE edge so the FIFO write lands two cycles after the fall
  assign push_c = (state == BUSY) && !busy_q;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count_q;
  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          wr_c;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_c   = bus.rdy_clr && !empty_c;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands
  assign wr_c    = push_c && (!full_c || pop_c);

  // Storage; cleared on reset so the head reads 8'h00 out of reset
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_c) begin
      mem[wptr[AW-1:0]] <= dout_q;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_c)  wptr <= wptr + PW'(1);
      if (pop_c) rptr <= rptr + PW'(1);
      count_q <= count_q + PW'(wr_c) - PW'(pop_c);
    end
  end

`ifdef UART_RX_CTRL_OVERRUN_EN
  logic overrun_q;
  logic drop_c;

  assign drop_c = push_c && full_c && !pop_c;

  // Sticky overrun: set by a dropped byte, cleared by a rdy_clr while empty
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (drop_c) begin
      overrun_q <= 1'b1;
    end else if (bus.rdy_clr && (count_q == '0)) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
`endif

  assign bus.rxclken = rxclken_q;
  assign bus.rdy     = (count_q != '0);
  assign bus.data    = mem[rptr[AW-1:0]];
  assign bus.count   = count_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with DIV=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling edge of rxclk.
module tb_uart_rx_ctrl;
  logic rxclk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  uart_rx_ctrl_if #(.DEPTH(4)) bus ();

  uart_rx_ctrl #(.DIV(4), .DEPTH(4)) dut (
    .rxclk (rxclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  task automatic tick();
    @(negedge rxclk);
  endtask

  // One receiver frame: busy for one cycle, then wait out the two-cycle capture latency
  task automatic push_byte(input logic [7:0] b);
    bus.dout    = b;
    bus.rx_busy = 1'b1;
    tick();
    bus.rx_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    bus.rdy_clr = 1'b1;
    tick();
    bus.rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.rxclken !== 1'b0 || bus.rdy !== 1'b0 || bus.data !== 8'h00 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: rxclken=%b rdy=%b data=%h count=%0d, required 0 0 00 0",
               bus.rxclken, bus.rdy, bus.data, bus.count);
    end
`ifdef UART_RX_CTRL_OVERRUN_EN
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b required 0", bus.overrun);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_divider();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    bus.en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.rxclken === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL div_pulse_count: got %0d required 5", pulses);
    end
    n_checks++;
    if (first != 4) begin
      n_fail++;
      $display("FAIL div_first_pulse: got cycle %0d required 4", first);
    end
    bus.en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rxclken !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL div_disabled: got %0d pulses required 0", pulses);
    end
    bus.en = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.rxclken !== 1'b0) pulses++;
    end
    tick();
    n_checks++;
    if (pulses != 0 || bus.rxclken !== 1'b1) begin
      n_fail++;
      $display("FAIL div_restart: early=%0d pulse4=%b, required 0 and 1", pulses, bus.rxclken);
    end
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    bus.dout    = 8'hA5;
    bus.rx_busy = 1'b1;
    repeat (10) tick();
    bus.rx_busy = 1'b0;
    tick();
    n_checks++;
    if (bus.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_latency_early: rdy=%b required 0", bus.rdy);
    end
    tick();
    n_checks++;
    if (bus.rdy !== 1'b1 || bus.data !== 8'hA5 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL frame_capture: rdy=%b data=%h count=%0d, required 1 a5 1",
               bus.rdy, bus.data, bus.count);
    end
    pop();
    n_checks++;
    if (bus.rdy !== 1'b0 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL frame_pop: rdy=%b count=%0d, required 0 0", bus.rdy, bus.count);
    end
  endtask

  task automatic test_order_wrap();
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    n_checks++;
    if (bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL order_fill_count: got %0d required 4", bus.count);
    end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      n_checks++;
      if (bus.data !== exp || bus.rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL order_data: got %h rdy=%b required %h rdy=1", bus.data, bus.rdy, exp);
      end
      pop();
    end
    for (int i = 5; i <= 7; i++) push_byte(8'(i));
    for (int i = 5; i <= 7; i++) begin
      exp = 8'(i);
      n_checks++;
      if (bus.data !== exp) begin
        n_fail++;
        $display("FAIL wrap_data: got %h required %h", bus.data, exp);
      end
      pop();
    end
    n_checks++;
    if (bus.count !== 3'd0 || bus.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_empty: count=%0d rdy=%b required 0 0", bus.count, bus.rdy);
    end
  endtask

  task automatic test_full_overrun();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    n_checks++;
    if (bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_count: got %0d required 4", bus.count);
    end
`ifdef UART_RX_CTRL_OVERRUN_EN
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b required 1", bus.overrun);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h10 + i);
      n_checks++;
      if (bus.data !== exp) begin
        n_fail++;
        $display("FAIL full_drain: got %h required %h", bus.data, exp);
      end
      pop();
    end
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL full_drained_count: got %0d required 0", bus.count);
    end
`ifdef UART_RX_CTRL_OVERRUN_EN
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b required 1", bus.overrun);
    end
`endif
    pop();
    n_checks++;
    if (bus.count !== 3'd0 || bus.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop_ignored: count=%0d rdy=%b required 0 0", bus.count, bus.rdy);
    end
`ifdef UART_RX_CTRL_OVERRUN_EN
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b required 0", bus.overrun);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
    bus.dout    = 8'h24;
    bus.rx_busy = 1'b1;
    tick();
    bus.rx_busy = 1'b0;
    tick();
    bus.rdy_clr = 1'b1;
    tick();
    bus.rdy_clr = 1'b0;
    n_checks++;
    if (bus.count !== 3'd4 || bus.data !== 8'h21) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d data=%h required 4 21", bus.count, bus.data);
    end
`ifdef UART_RX_CTRL_OVERRUN_EN
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop_overrun: got %b required 0", bus.overrun);
    end
`endif
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(8'h20 + i);
      n_checks++;
      if (bus.data !== exp) begin
        n_fail++;
        $display("FAIL full_push_pop_drain: got %h required %h", bus.data, exp);
      end
      pop();
    end
  endtask

  task automatic test_edge_push_pop();
    // Empty: the simultaneous pop is ignored and the push lands
    bus.dout    = 8'h33;
    bus.rx_busy = 1'b1;
    tick();
    bus.rx_busy = 1'b0;
    tick();
    bus.rdy_clr = 1'b1;
    tick();
    bus.rdy_clr = 1'b0;
    n_checks++;
    if (bus.count !== 3'd1 || bus.data !== 8'h33) begin
      n_fail++;
      $display("FAIL empty_push_pop: count=%0d data=%h required 1 33", bus.count, bus.data);
    end
    // Non-empty: both execute, count unchanged
    push_byte(8'h44);
    bus.dout    = 8'h55;
    bus.rx_busy = 1'b1;
    tick();
    bus.rx_busy = 1'b0;
    tick();
    bus.rdy_clr = 1'b1;
    tick();
    bus.rdy_clr = 1'b0;
    n_checks++;
    if (bus.count !== 3'd2 || bus.data !== 8'h44) begin
      n_fail++;
      $display("FAIL mid_push_pop: count=%0d data=%h required 2 44", bus.count, bus.data);
    end
    pop();
    n_checks++;
    if (bus.data !== 8'h55 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_push_pop_next: data=%h count=%0d required 55 1", bus.data, bus.count);
    end
    pop();
  endtask

  task automatic test_reset_mid_frame();
    push_byte(8'h61);
    push_byte(8'h62);
    bus.en      = 1'b1;
    bus.dout    = 8'h63;
    bus.rx_busy = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.count !== 3'd2) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d required 2", bus.count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rdy !== 1'b0 || bus.count !== 3'd0 || bus.data !== 8'h00 || bus.rxclken !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b count=%0d data=%h rxclken=%b, required 0 0 00 0",
               bus.rdy, bus.count, bus.data, bus.rxclken);
    end
    bus.en = 1'b0;
    tick();
    tick();
    rst_n       = 1'b1;
    bus.rx_busy = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (bus.rdy !== 1'b0 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_push: rdy=%b count=%0d required 0 0", bus.rdy, bus.count);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.rx_busy = 1'b0;
    bus.dout    = 8'h00;
    bus.rdy_clr = 1'b0;
    test_reset();
    test_divider();
    test_single_frame();
    test_order_wrap();
    test_full_overrun();
    test_full_push_pop();
    test_edge_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
